// File: rtl/slice_compare_sequencer.sv
// Multi-cycle unsigned compare of two WORDS*N-bit operands through one shared N-bit
// slice comparator, scanning from the most-significant slice down to the first difference.
module slice_compare_sequencer #(
    parameter int N     = 4,
    parameter int WORDS = 4,
    localparam int W    = N * WORDS,
    localparam int CW   = $clog2(WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          busy,
    output logic          done,
    output logic          y2,
    output logic          y1,
    output logic          y0,
    output logic [CW-1:0] cycles
);

    localparam int IW = (WORDS > 2) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [IW-1:0] r_idx;
    logic          r_busy;
    logic          r_done;
    logic          r_y2;
    logic          r_y1;
    logic          r_y0;
    logic [CW-1:0] r_cycles;

    logic [N-1:0]  w_sa;
    logic [N-1:0]  w_sb;
    logic          w_gt;
    logic          w_eq;

    // The single shared slice comparator.
    always_comb begin
        w_sa = r_a[r_idx*N +: N];
        w_sb = r_b[r_idx*N +: N];
        w_gt = (w_sa > w_sb);
        w_eq = (w_sa == w_sb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_y2     <= 1'b0;
            r_y1     <= 1'b0;
            r_y0     <= 1'b0;
            r_cycles <= '0;
        end else begin
            case (r_state)
                S_CMP: begin
                    r_cycles <= r_cycles + CW'(1);
                    if (!w_eq) begin
                        r_y2    <= w_gt;
                        r_y0    <= ~w_gt;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_idx == '0) begin
                        r_y1    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; done lasts one cycle either way.
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_idx    <= IW'(WORDS - 1);
                        r_y2     <= 1'b0;
                        r_y1     <= 1'b0;
                        r_y0     <= 1'b0;
                        r_cycles <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CMP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign y2     = r_y2;
    assign y1     = r_y1;
    assign y0     = r_y0;
    assign cycles = r_cycles;

endmodule
